// File: rtl/inv_key_schedule_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the AES-128 reverse key schedule.
package inv_key_schedule_pkg;
  localparam int WORD_W = 32;
  localparam int KEY_W  = 128;

  localparam logic [7:0] AES_RCON_LAST = 8'h36;
  localparam logic [7:0] RCON_POLY     = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } ks_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return b[0] ? (((b ^ RCON_POLY) >> 1) | 8'h80) : (b >> 1);
  endfunction

  // rcon(1)=01 ... rcon(10)=AES_RCON_LAST
  function automatic logic [7:0] rcon(input int i);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < 10; k++)
      if (k < i) r = xtime(r);
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction
endpackage

// File: rtl/inv_key_schedule_step.sv
// Combinational inverse key-expansion step: round key i and its rcon -> round key i-1.
module inv_key_step
  import inv_key_schedule_pkg::*;
(
  input  logic [KEY_W-1:0]  i_rk,
  input  logic [7:0]        i_rcon,
  output logic [KEY_W-1:0]  o_prev_rk
);
  logic [WORD_W-1:0]   w_w0, w_w1, w_w2, w_w3;
  logic [WORD_W-1:0]   w_n0, w_n1, w_n2, w_n3;
  logic [3:0][7:0]     w_rot, w_sub;
  logic [WORD_W-1:0]   w_g;

  assign {w_w0, w_w1, w_w2, w_w3} = i_rk;

  assign w_n3 = w_w3 ^ w_w2;
  assign w_n2 = w_w2 ^ w_w1;
  assign w_n1 = w_w1 ^ w_w0;

  assign w_rot = {w_n3[23:0], w_n3[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      sub_byte u_sbox (
        .i_byte (w_rot[gi]),
        .o_byte (w_sub[gi])
      );
    end
  endgenerate

  assign w_g       = w_sub ^ {i_rcon, 24'h0};
  assign w_n0      = w_w0 ^ w_g;
  assign o_prev_rk = {w_n0, w_n1, w_n2, w_n3};
endmodule

// File: rtl/sub_byte.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module sub_byte
  import inv_key_schedule_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  logic [7:0] w_inv;

  // x^254 == x^-1 (and maps 0 to 0): accumulate x^2, x^4 ... x^128
  always_comb begin
    logic [7:0] sq;
    w_inv = 8'h01;
    sq    = i_byte;
    for (int k = 1; k < 8; k++) begin
      sq    = gf_mul(sq, sq);
      w_inv = gf_mul(w_inv, sq);
    end
  end

  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;
endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 reverse key expander: emits round keys NUM_ROUNDS..0 over a valid/ready stream.
// Optional macro INV_KS_ZEROIZE_EN wipes rk/rcon on completion or abort.
module inv_key_schedule
  import inv_key_schedule_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KEY_W-1:0]  last_key,
  input  logic              abort,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [KEY_W-1:0]  rk,
  output logic [3:0]        rk_round,
  output logic              done
);
  localparam logic [3:0] ROUND_INIT = 4'(NUM_ROUNDS);
  localparam logic [7:0] RCON_INIT  = rcon(NUM_ROUNDS);

  ks_state_e        r_state, w_state_nxt;
  logic [KEY_W-1:0] r_rk;
  logic [KEY_W-1:0] w_prev_rk;
  logic [3:0]       r_round;
  logic [7:0]       r_rcon;
  logic             r_done;
  logic             w_accept, w_last;

  assign rk_valid = (r_state == EMIT);
  assign busy     = (r_state != IDLE);
  assign rk       = r_rk;
  assign rk_round = r_round;
  assign done     = r_done;

  assign w_accept = rk_valid & rk_ready;
  assign w_last   = w_accept & (r_round == 4'd0);

  inv_key_step u_step (
    .i_rk      (r_rk),
    .i_rcon    (r_rcon),
    .o_prev_rk (w_prev_rk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Capture is folded into the IDLE->EMIT edge; LOAD only exists as a name.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start)  w_state_nxt = EMIT;
        LOAD:    w_state_nxt = EMIT;
        EMIT:    if (w_last) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rk    <= '0;
      r_round <= 4'd0;
      r_rcon  <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
`ifdef INV_KS_ZEROIZE_EN
        r_rk   <= '0;
        r_rcon <= 8'h00;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_rk    <= last_key;
              r_round <= ROUND_INIT;
              r_rcon  <= RCON_INIT;
            end
          end
          EMIT: begin
            if (w_last) begin
              r_done <= 1'b1;
`ifdef INV_KS_ZEROIZE_EN
              r_rk   <= '0;
              r_rcon <= 8'h00;
`endif
            end else if (w_accept) begin
              r_rk    <= w_prev_rk;
              r_round <= 4'(r_round - 4'd1);
              r_rcon  <= inv_xtime(r_rcon);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: forward AES-128 key expansion as reference, random keys and backpressure.
module tb_inv_key_schedule;
  logic         clk = 1'b0;
  logic         rst_n, start, abort, rk_ready;
  logic [127:0] last_key;
  logic         busy, rk_valid, done;
  logic [127:0] rk;
  logic [3:0]   rk_round;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [0:255][7:0] sbox_t = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  logic [0:9][7:0] rc_t = 80'h01020408102040801b36;

  logic [127:0] exp_k [0:10];

  inv_key_schedule #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .last_key(last_key), .abort(abort),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk),
    .rk_round(rk_round), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Standard forward expansion from round key 0; round r lands in exp_k[r].
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc_t[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // bp: random rk_ready; inj: random start/last_key while emitting;
  // stop_at >= 0: abort (use_rst=0) or reset pulse (use_rst=1) when that round is shown.
  task automatic run_seq(input logic [127:0] key0, input bit bp, input bit inj,
                         input int stop_at, input bit use_rst);
    int idx, cyc;
    bit rdy;
    expand(key0);
    @(negedge clk);
    start    = 1'b1;
    last_key = exp_k[10];
    rk_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    start    = 1'b0;
    last_key = {$urandom, $urandom, $urandom, $urandom};
    idx = 10;
    cyc = 0;
    while (idx >= 0) begin
      chk("valid", 128'(rk_valid), 128'd1);
      chk("busy", 128'(busy), 128'd1);
      chk("round", 128'(rk_round), 128'(idx));
      chk("rk", rk, exp_k[idx]);
      if (key0 == A1_KEY && idx == 9) chk("a1_r9", rk, 128'hac7766f319fadc2128d12941575c006e);
      if (key0 == A1_KEY && idx == 0) chk("a1_r0", rk, A1_KEY);
      if (idx == stop_at) begin
        if (!use_rst) begin
          abort    = 1'b1;
          rk_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          abort = 1'b0;
          chk("abort_valid", 128'(rk_valid), 128'd0);
          chk("abort_done", 128'(done), 128'd0);
          chk("abort_busy", 128'(busy), 128'd0);
`ifdef INV_KS_ZEROIZE_EN
          chk("abort_rk", rk, 128'd0);
`else
          chk("abort_rk", rk, exp_k[idx]);
`endif
          @(negedge clk);
          chk("abort_nodone", 128'(done), 128'd0);
        end else begin
          rst_n = 1'b0;
          #1;
          chk("rst_outs", {rk, 4'(rk_round), 1'(rk_valid), 1'(busy), 1'(done)}, '0);
          @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          @(negedge clk);
          chk("rst_idle", {rk, 4'(rk_round), 1'(rk_valid), 1'(busy), 1'(done)}, '0);
        end
        rk_ready = 1'b0;
        return;
      end
      rdy      = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rdy;
      if (inj) begin
        start    = 1'($urandom_range(0, 1));
        last_key = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      cyc++;
      if (rdy) idx--;
      if (cyc > 400) begin
        n_chk++;
        $error("FAIL timeout observed_round=%0d expected_round=%0d", rk_round, idx);
        break;
      end
    end
    start    = 1'b0;
    rk_ready = 1'b0;
    chk("done_pulse", 128'(done), 128'd1);
    chk("end_valid", 128'(rk_valid), 128'd0);
    chk("end_busy", 128'(busy), 128'd0);
    @(negedge clk);
    chk("done_once", 128'(done), 128'd0);
`ifdef INV_KS_ZEROIZE_EN
    chk("end_rk", rk, 128'd0);
`else
    chk("end_rk", rk, exp_k[0]);
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    rk_ready = 1'b0;
    last_key = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", {rk, 4'(rk_round), 1'(rk_valid), 1'(busy), 1'(done)}, '0);
    rst_n = 1'b1;

    run_seq(A1_KEY, 1'b0, 1'b0, -1, 1'b0);
    chk("a1_r10_model", exp_k[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int n = 0; n < 3; n++)
      run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, -1, 1'b0);

    for (int n = 0; n < 2; n++)
      run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, -1, 1'b0);

    @(negedge clk);
    start    = 1'b1;
    abort    = 1'b1;
    last_key = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_valid", 128'(rk_valid), 128'd0);
    chk("start_abort_busy", 128'(busy), 128'd0);

    run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 5, 1'b0);
    run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, -1, 1'b0);

    run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 3, 1'b1);
    run_seq(A1_KEY, 1'b1, 1'b0, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
- Sequential AES-128 reverse key expander for the decryption datapath.
- Takes the final round key (round NUM_ROUNDS) and emits round keys NUM_ROUNDS down to 0, one per accepted beat, over a valid/ready stream.
- Computes each earlier key from the later one, so the inverse cipher needs no 11-entry key store.
- Reuses the existing sub_byte S-box, four instances.

Parameters:
- NUM_ROUNDS, 10, number of rounds; legal 1..10. The first Rcon used is rcon(NUM_ROUNDS).

Ports:
- clk  input  1  clock; all state is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  load last_key and begin; honoured only in IDLE.
- last_key  input  128  round-NUM_ROUNDS key; word0 = [127:96], word3 = [31:0].
- abort  input  1  synchronous return to IDLE from any state.
- busy  output  1  high in LOAD/EMIT.
- rk_valid  output  1  rk/rk_round hold a valid key.
- rk_ready  input  1  consumer accepts the current key.
- rk  output  128  current round key.
- rk_round  output  4  round index of rk.
- done  output  1  one-cycle pulse after round 0 is accepted.

Behaviour:
- Reset (async, rst_n=0) clears all registers: state=IDLE, busy=0, rk_valid=0, rk=0, rk_round=0, done=0, rcon=0.
- States and transitions:
  - IDLE: on start, capture last_key into rk, set rk_round=NUM_ROUNDS and rcon=rcon(NUM_ROUNDS), then go to EMIT. rk_valid=1 on the next cycle (latency 1).
  - EMIT: rk_valid=1. rk, rk_round and rcon are stable until accepted.
    - Accept (rk_valid & rk_ready) with rk_round>0: load the previous key; rk_round-1; rcon=inv_xtime(rcon). The next key is valid on the following cycle, so there are no bubbles.
    - Accept with rk_round==0: rk_valid=0, done=1 for one cycle, go to IDLE.
  - LOAD: transient name for the capture cycle; may be merged into IDLE->EMIT.
- Previous-key step, with words w0..w3 of rk:
  - n3 = w3^w2
  - n2 = w2^w1
  - n1 = w1^w0
  - n0 = w0 ^ g
  - g = SubWord(RotWord(n3)) ^ {rcon,24'h0}. RotWord output bytes are n3[23:16], n3[15:8], n3[7:0], n3[31:24].
  - S-boxes are fed combinationally from n3; a single-cycle path is acceptable.
- Rcon arithmetic: inv_xtime(b) = b[0] ? ((b^8'h1B)>>1)|8'h80 : b>>1. Sequence from 8'h36: 1B, 80, 40, 20, 10, 08, 04, 02, 01.
- Boundary conditions:
  - start while busy: ignored.
  - start and abort together in IDLE: abort wins.
  - abort in EMIT: rk_valid=0 next cycle, no done pulse.
  - rk_ready low: everything holds indefinitely.
  - rk_ready high during the capture cycle: no effect.
  - rst_n low mid-sequence: immediate clear; the sequence is not resumed.
  - Full sequence = NUM_ROUNDS+1 beats.

Optional Feature:
- Macro INV_KS_ZEROIZE_EN.
- Defined: rk and rcon are cleared to 0 in the cycle done pulses and on abort. rk reads 0 whenever rk_valid=0 after a completed or aborted sequence.
- Undefined: rk retains round key 0 (or the key at abort) until the next start.

Decomposition:
- Shared package holds:
  - AES_RCON_LAST=8'h36
  - the RCON_POLY=8'h1B constant
  - localparam function rcon(i)
  - word/key width constants (WORD_W=32, KEY_W=128)
  - state encoding typedef (IDLE, LOAD, EMIT).
- One natural sub-module: inv_key_step, combinational (rk, rcon -> prev_rk), wrapping the four sub_byte instances.
- FSM and registers stay in inv_key_schedule.

Test Plan:
1. FIPS-197 A.1: start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready=1. Required:
   - round 10 key on cycle t+1;
   - round 9 = ac7766f319fadc2128d12941575c006e;
   - round 0 = 2b7e151628aed2a6abf7158809cf4f3c on t+11;
   - done on t+12.
2. Backpressure: toggle rk_ready randomly across the same sequence -> identical 11 keys in order; rk/rk_round never change while rk_valid=1 & rk_ready=0.
3. start pulses during EMIT with a different last_key -> ignored; sequence unchanged.
4. abort at rk_round=5 -> rk_valid=0 next cycle, no done; a new start runs a full sequence correctly.
5. rst_n pulse low at rk_round=3 -> all outputs 0 asynchronously; IDLE after release.
6. INV_KS_ZEROIZE_EN defined -> rk==0 the cycle after done. Undefined -> rk==2b7e1516... held.
